// File: rtl/fifo_dual_data.sv
// fifo_dual_data
// Single-clock first-word-fall-through FIFO. Each entry holds two fields that
// are always written and read together: a wide payload (data0) and a tag
// (data1). It is the output queue of the branch target calculator, where
// data0 is the computed target and data1 is the ROB address.
//
// Ports
//   clk      in   clock; all state updates on the rising edge
//   rstn     in   asynchronous active-low reset; clears pointers and storage
//   i_WrtEn  in   write request; pushes {i_data0,i_data1} unless full
//   i_data0  in   write field 0 (DATA0SIZE bits)
//   i_data1  in   write field 1 (DATA1SIZE bits)
//   i_RdEn   in   read request; pops the head entry unless empty
//   o_data0  out  head entry field 0, combinational from the read pointer
//   o_data1  out  head entry field 1, combinational from the read pointer
//   o_Full   out  all 2**FIFODEPTH entries occupied
//   o_Empty  out  no entries occupied
//
// Handshake: a push is accepted at a rising edge exactly when
// i_WrtEn && !o_Full; a pop is accepted exactly when i_RdEn && !o_Empty.
// Both decisions use the pre-edge status, so a write while full is dropped
// even when a read frees a slot on the same edge. o_data0/o_data1 are only
// meaningful while o_Empty is low.
module fifo_dual_data #(
   parameter int FIFODEPTH = 3,
   parameter int DATA0SIZE = 32,
   parameter int DATA1SIZE = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 i_WrtEn,
   input  logic [DATA0SIZE-1:0] i_data0,
   input  logic [DATA1SIZE-1:0] i_data1,
   input  logic                 i_RdEn,
   output logic [DATA0SIZE-1:0] o_data0,
   output logic [DATA1SIZE-1:0] o_data1,
   output logic                 o_Full,
   output logic                 o_Empty
);

   localparam int ENTRIES = 1 << FIFODEPTH;

   // Storage indexed by physical slot.
   logic [DATA0SIZE-1:0] T_DATA0 [ENTRIES];
   logic [DATA1SIZE-1:0] T_DATA1 [ENTRIES];

   // One extra wrap bit above the slot index tells full from empty when the
   // index bits match.
   logic [FIFODEPTH:0]   wr_ptr;
   logic [FIFODEPTH:0]   rd_ptr;
   logic [FIFODEPTH-1:0] wr_idx;
   logic [FIFODEPTH-1:0] rd_idx;
   logic                 do_wr;
   logic                 do_rd;

   assign wr_idx  = wr_ptr[FIFODEPTH-1:0];
   assign rd_idx  = rd_ptr[FIFODEPTH-1:0];

   assign o_Empty = (wr_ptr == rd_ptr);
   assign o_Full  = (wr_idx == rd_idx) && (wr_ptr[FIFODEPTH] != rd_ptr[FIFODEPTH]);

   assign do_wr   = i_WrtEn && !o_Full;
   assign do_rd   = i_RdEn  && !o_Empty;

   // Fall-through head; shows stale slot content while empty.
   assign o_data0 = T_DATA0[rd_idx];
   assign o_data1 = T_DATA1[rd_idx];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            T_DATA0[i] <= '0;
            T_DATA1[i] <= '0;
         end
      end else begin
         if (do_wr) begin
            T_DATA0[wr_idx] <= i_data0;
            T_DATA1[wr_idx] <= i_data1;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_dual_data.sv
// tb_fifo_dual_data
// Directed bench for fifo_dual_data with default parameters (8 entries,
// 32-bit data0, 8-bit data1). Outputs are sampled at the falling edge.
module tb_fifo_dual_data;

   logic        clk;
   logic        rstn;
   logic        i_WrtEn;
   logic [31:0] i_data0;
   logic [7:0]  i_data1;
   logic        i_RdEn;
   logic [31:0] o_data0;
   logic [7:0]  o_data1;
   logic        o_Full;
   logic        o_Empty;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_q0[$];
   logic [7:0]  exp_q1[$];

   fifo_dual_data dut (
      .clk     (clk),
      .rstn    (rstn),
      .i_WrtEn (i_WrtEn),
      .i_data0 (i_data0),
      .i_data1 (i_data1),
      .i_RdEn  (i_RdEn),
      .o_data0 (o_data0),
      .o_data1 (o_data1),
      .o_Full  (o_Full),
      .o_Empty (o_Empty)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Called away from the rising edge; applies inputs for one edge and
   // returns at the following falling edge.
   task automatic cycle(input logic wr, input logic [31:0] d0, input logic [7:0] d1, input logic rd);
      i_WrtEn = wr;
      i_data0 = d0;
      i_data1 = d1;
      i_RdEn  = rd;
      @(posedge clk);
      #1;
      i_WrtEn = 1'b0;
      i_RdEn  = 1'b0;
      @(negedge clk);
   endtask

   task automatic push(input logic [31:0] d0, input logic [7:0] d1);
      cycle(1'b1, d0, d1, 1'b0);
      exp_q0.push_back(d0);
      exp_q1.push_back(d1);
   endtask

   task automatic check_head(input string tag);
      check({tag, "_d0"}, o_data0, exp_q0[0]);
      check({tag, "_d1"}, {24'h0, o_data1}, {24'h0, exp_q1[0]});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rstn    = 1'b0;
      i_WrtEn = 1'b0;
      i_RdEn  = 1'b0;
      i_data0 = '0;
      i_data1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      // Reset state
      check("rst_empty", {31'h0, o_Empty}, 32'd1);
      check("rst_full",  {31'h0, o_Full},  32'd0);
      check("rst_d0",    o_data0, 32'd0);
      check("rst_d1",    {24'h0, o_data1}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         check("rst_t0", dut.T_DATA0[i], 32'd0);
         check("rst_t1", {24'h0, dut.T_DATA1[i]}, 32'd0);
      end

      // Fill
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, i * 100 + 7, i[7:0], 1'b0);
         check("fill_full",  {31'h0, o_Full},  (i == 7) ? 32'd1 : 32'd0);
         check("fill_empty", {31'h0, o_Empty}, 32'd0);
      end
      for (int i = 0; i < 8; i++) begin
         check("fill_t0", dut.T_DATA0[i], i * 100 + 7);
         check("fill_t1", {24'h0, dut.T_DATA1[i]}, i);
      end
      check("fill_d0", o_data0, 32'd7);
      check("fill_d1", {24'h0, o_data1}, 32'd0);

      // Overflow is dropped
      cycle(1'b1, 32'hDEAD, 8'hEE, 1'b0);
      check("ovf_full", {31'h0, o_Full}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         check("ovf_t0", dut.T_DATA0[i], i * 100 + 7);
         check("ovf_t1", {24'h0, dut.T_DATA1[i]}, i);
      end

      // Drain in order
      for (int i = 0; i < 8; i++) begin
         check("rd_d0",    o_data0, i * 100 + 7);
         check("rd_d1",    {24'h0, o_data1}, i);
         check("rd_empty", {31'h0, o_Empty}, 32'd0);
         cycle(1'b0, '0, '0, 1'b1);
         check("rd_full",  {31'h0, o_Full}, 32'd0);
      end
      check("drain_empty", {31'h0, o_Empty}, 32'd1);

      // Underflow ignored
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, '0, '0, 1'b1);
         check("unf_empty", {31'h0, o_Empty}, 32'd1);
         check("unf_full",  {31'h0, o_Full},  32'd0);
      end
      push(32'h55, 8'h3);
      check("unf_wr_empty", {31'h0, o_Empty}, 32'd0);
      check("unf_wr_d0", o_data0, 32'h55);
      check("unf_wr_d1", {24'h0, o_data1}, 32'h3);
      check("unf_slot0", dut.T_DATA0[0], 32'h55);

      // Simultaneous read/write with three entries, slots 0..2 occupied
      push(32'h60, 8'h4);
      push(32'h61, 8'h5);
      for (int k = 0; k < 10; k++) begin
         check_head("sim_head");
         cycle(1'b1, 32'h200 + k, 8'h10 + k[7:0], 1'b1);
         void'(exp_q0.pop_front());
         void'(exp_q1.pop_front());
         exp_q0.push_back(32'h200 + k);
         exp_q1.push_back(8'h10 + k[7:0]);
         check("sim_empty", {31'h0, o_Empty}, 32'd0);
         check("sim_full",  {31'h0, o_Full},  32'd0);
      end
      // Writes went to slots 3..7 then wrapped to 0..4.
      check("sim_wrap_t0", dut.T_DATA0[0], 32'h205);
      check("sim_wrap_t1", {24'h0, dut.T_DATA1[4]}, 32'h19);
      check_head("sim_after");

      // Fill to full, then read and write together: only the read happens.
      for (int k = 0; k < 5; k++) begin
         check("top_full_pre", {31'h0, o_Full}, 32'd0);
         push(32'h300 + k, 8'h20 + k[7:0]);
      end
      check("top_full", {31'h0, o_Full}, 32'd1);
      cycle(1'b1, 32'hBAD, 8'hBB, 1'b1);
      void'(exp_q0.pop_front());
      void'(exp_q1.pop_front());
      check("both_full_full", {31'h0, o_Full}, 32'd0);
      for (int k = 0; k < 7; k++) begin
         check_head("both_full_drain");
         check("both_full_nempty", {31'h0, o_Empty}, 32'd0);
         cycle(1'b0, '0, '0, 1'b1);
         void'(exp_q0.pop_front());
         void'(exp_q1.pop_front());
      end
      check("both_full_empty", {31'h0, o_Empty}, 32'd1);

      // Reset mid-operation with five entries
      for (int k = 0; k < 5; k++) push(32'h400 + k, 8'h30 + k[7:0]);
      check("mid_pre_empty", {31'h0, o_Empty}, 32'd0);
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      check("mid_empty", {31'h0, o_Empty}, 32'd1);
      check("mid_full",  {31'h0, o_Full},  32'd0);
      check("mid_d0",    o_data0, 32'd0);
      check("mid_d1",    {24'h0, o_data1}, 32'd0);
      #1 rstn = 1'b1;
      @(negedge clk);
      exp_q0.delete();
      exp_q1.delete();
      push(32'hABC, 8'h7);
      check("mid_slot0_t0", dut.T_DATA0[0], 32'hABC);
      check("mid_slot0_t1", {24'h0, dut.T_DATA1[0]}, 32'h7);
      check("mid_slot1_t0", dut.T_DATA0[1], 32'd0);
      check_head("mid_head");
      check("mid_wr_empty", {31'h0, o_Empty}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Safety bound on total run time.
   initial begin
      #100000;
      n_err++;
      $display("FAIL timeout: got no finish expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_dual_data.md
Name: fifo_dual_data

Overview:
- Synchronous single-clock FIFO that stores two independent data fields per entry: a wide payload (data0) and a tag (data1).
- Both fields are written and read together.
- Used as the output queue of the branch target calculator: data0 is the computed 32-bit target, data1 is the ROB address.
- First-word-fall-through read port with full/empty status.

Parameters:
- FIFODEPTH, 3, log2 of entry count; the FIFO holds 2**FIFODEPTH entries (8 by default).
- DATA0SIZE, 32, width of the data0 field.
- DATA1SIZE, 8, width of the data1 field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- i_WrtEn  in  1  write request; pushes i_data0/i_data1 as one entry.
- i_data0  in  DATA0SIZE  write payload field 0.
- i_data1  in  DATA1SIZE  write payload field 1.
- i_RdEn  in  1  read request; pops the head entry.
- o_data0  out  DATA0SIZE  head entry field 0.
- o_data1  out  DATA1SIZE  head entry field 1.
- o_Full  out  1  all 2**FIFODEPTH entries occupied.
- o_Empty  out  1  no entries occupied.

Behaviour:
- Storage: two arrays T_DATA0[0..2**FIFODEPTH-1] and T_DATA1[0..2**FIFODEPTH-1].
  - Both arrays are indexed by physical slot.
  - These names are fixed; benches probe them hierarchically.
- Pointers: write and read pointers are FIFODEPTH+1 bits wide. The low FIFODEPTH bits are the slot index; the MSB is the wrap bit.
- Status, combinational from pointers:
  - o_Empty = (wr_ptr == rd_ptr).
  - o_Full = index bits equal and wrap bits differ.
- Reset (rstn=0, asynchronous):
  - Pointers go to 0 and all storage entries clear to 0.
  - o_Empty=1, o_Full=0, o_data0=0, o_data1=0.
  - Reset mid-operation discards all contents immediately.
- Write:
  - If i_WrtEn && !o_Full at a rising edge, {i_data0,i_data1} is stored in slot wr_ptr[FIFODEPTH-1:0] and wr_ptr increments.
  - The first write after reset lands in slot 0, the next in slot 1, and so on.
  - A write while full is silently dropped; no state changes.
- Read:
  - If i_RdEn && !o_Empty at a rising edge, rd_ptr increments.
  - A read while empty is ignored.
- Output:
  - First-word-fall-through. o_data0/o_data1 = T_DATA0/T_DATA1[rd_ptr index], combinational, zero-latency.
  - Output is valid whenever o_Empty=0.
  - When empty, the output shows the stale slot content (0 after reset); consumers must qualify it with o_Empty.
- Latency: a written entry is visible on o_data0/o_data1 and clears o_Empty the cycle after the write edge.
- Simultaneous events:
  - Read and write while neither full nor empty: both occur and the occupancy count is unchanged.
  - Both while empty: only the write occurs.
  - Both while full: only the read occurs; the write is dropped. Full/empty use the pre-edge state.
- Wrap-around: pointers wrap modulo 2**(FIFODEPTH+1). Slot indices wrap modulo 2**FIFODEPTH with no gap.
- No flush input; the only clear is via rstn.
- Storage is not modified by reads.

Decomposition:
- No shared package needed; widths come from parameters.
- Single flat module with no sub-modules.
- Pointer/status logic and storage live in one always_ff plus combinational assigns.

Test Plan:
- Reset state: drive rstn=0 for 2 cycles, then release -> o_Empty=1, o_Full=0, o_data0=0, o_data1=0, all T_DATA0/T_DATA1 entries 0.
- Fill: write 8 entries (data0=i*100+7, data1=i) on consecutive cycles -> o_Full=1 after the 8th edge; T_DATA0[i]=i*100+7 and T_DATA1[i]=i for i=0..7; o_data0=7, o_data1=0.
- Overflow and FIFO order:
  - Write data0=0xDEAD while full -> ignored; T_DATA0 unchanged.
  - Then read 8 times -> o_data0 sequence 7,107,...,707, o_data1 sequence 0..7.
  - o_Empty=1 after the last read.
- Underflow: assert i_RdEn while empty for 3 cycles, then write 0x55/0x3 -> one cycle later o_Empty=0, o_data0=0x55, o_data1=0x3. The pointer was not corrupted by the empty reads.
- Simultaneous read and write, with wrap:
  - With 3 entries occupied, assert both for 10 cycles -> occupancy stays 3, slot index wraps past 7 to 0, outputs stay in order.
  - When full, both asserted -> read only, o_Full deasserts.
- Reset mid-operation: with 5 entries occupied, pulse rstn low asynchronously between edges -> o_Empty=1 and o_Full=0 immediately; the next write lands in slot 0.
